// File: rtl/cga_hdmi_timing_ctrl_pkg.sv
// rtl/cga_hdmi_timing_ctrl_pkg.sv - timing FSM states and default CGA raster constants
package cga_hdmi_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } timing_state_t;

  localparam logic [1:0] ST_SEARCH  = 2'(SEARCH);
  localparam logic [1:0] ST_MEASURE = 2'(MEASURE);
  localparam logic [1:0] ST_LOCKED  = 2'(LOCKED);

  localparam int CGA_H_TOTAL  = 912;
  localparam int CGA_V_TOTAL  = 262;
  localparam int CGA_H_ACTIVE = 640;
  localparam int CGA_V_ACTIVE = 200;

endpackage

// File: rtl/cga_hdmi_timing_ctrl_if.sv
// rtl/cga_hdmi_timing_ctrl_if.sv - raw CGA sync in, HDMI timing window and status out
interface cga_hdmi_timing_ctrl_if #(
  parameter int H_W = 10,
  parameter int V_W = 9
);
  logic           hsync;
  logic           vsync;
  logic           display_enable;
  logic           hs_out;
  logic           vs_out;
  logic           locked;
  logic [H_W-1:0] h_period;
  logic [V_W-1:0] v_lines;

  modport master (
    output hsync, vsync,
    input  display_enable, hs_out, vs_out, locked, h_period, v_lines
  );

  modport slave (
    input  hsync, vsync,
    output display_enable, hs_out, vs_out, locked, h_period, v_lines
  );
endinterface

// File: rtl/cga_hdmi_timing_ctrl_meter.sv
// rtl/cga_hdmi_timing_ctrl_meter.sv - sync rising-edge detect, saturating counter, period capture
module cga_sync_meter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         sync_i,
  input  logic         en_i,
  output logic         rise_o,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] next_period_o,
  output logic [W-1:0] period_o,
  output logic         sat_o
);
  localparam logic [W-1:0] CNT_MAX = '1;

  logic         sync_d1_q;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] period_q, period_d;

  assign rise_o        = sync_i & ~sync_d1_q;
  assign sat_o         = (cnt_q == CNT_MAX);
  // Capture saturates too, so a lost sync reads as max period rather than wrapping to 0.
  assign next_period_o = sat_o ? CNT_MAX : cnt_q + 1'b1;
  assign cnt_o         = cnt_q;
  assign period_o      = period_q;

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (rise_o) begin
      cnt_d    = '0;
      period_d = next_period_o;
    end else if (en_i && !sat_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_d1_q <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
    end else begin
      sync_d1_q <= sync_i;
      cnt_q     <= cnt_d;
      period_q  <= period_d;
    end
  end
endmodule

// File: rtl/cga_hdmi_timing_ctrl.sv
// rtl/cga_hdmi_timing_ctrl.sv - CGA raster lock tracker and HDMI display_enable generator
module cga_hdmi_timing_ctrl
  import cga_hdmi_pkg::*;
#(
  parameter int H_W         = 10,
  parameter int V_W         = 9,
  parameter int H_START     = 80,
  parameter int H_ACTIVE    = 640,
  parameter int V_START     = 20,
  parameter int V_ACTIVE    = 200,
  parameter int H_TOL       = 2,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  cga_hdmi_timing_ctrl_if.slave  vid
);
  localparam logic [H_W:0] H_LO   = (H_W+1)'(H_START);
  localparam logic [H_W:0] H_HI   = (H_W+1)'(H_START + H_ACTIVE);
  localparam logic [V_W:0] V_LO   = (V_W+1)'(V_START);
  localparam logic [V_W:0] V_HI   = (V_W+1)'(V_START + V_ACTIVE);
  localparam logic [H_W:0] TOL    = (H_W+1)'(H_TOL);
  localparam logic [2:0]   LOCK_N = 3'(LOCK_FRAMES);

  logic           hs_rise, vs_rise, h_sat, v_sat;
  logic [H_W-1:0] h_cnt, h_new, h_period;
  logic [V_W-1:0] v_cnt, v_new, v_lines;

  cga_sync_meter #(.W(H_W)) u_h_meter (
    .clk           (clk),
    .reset_n       (reset_n),
    .sync_i        (vid.hsync),
    .en_i          (1'b1),
    .rise_o        (hs_rise),
    .cnt_o         (h_cnt),
    .next_period_o (h_new),
    .period_o      (h_period),
    .sat_o         (h_sat)
  );

  cga_sync_meter #(.W(V_W)) u_v_meter (
    .clk           (clk),
    .reset_n       (reset_n),
    .sync_i        (vid.vsync),
    .en_i          (hs_rise),
    .rise_o        (vs_rise),
    .cnt_o         (v_cnt),
    .next_period_o (v_new),
    .period_o      (v_lines),
    .sat_o         (v_sat)
  );

  logic [1:0]     state_q, state_d;
  logic [2:0]     stable_q, stable_d;
  logic [H_W-1:0] ref_h_q, ref_h_d;
  logic           ref_valid_q, ref_valid_d;
  logic           frame_ok_q, frame_ok_d;
  logic           vl_valid_q, vl_valid_d;
  logic           locked_q, de_q, hs_out_q, vs_out_q;

  logic [H_W:0]   delta;
  logic           per_bad, vl_change, h_win, v_win;

  assign delta = ({1'b0, h_new} >= {1'b0, ref_h_q}) ? ({1'b0, h_new} - {1'b0, ref_h_q})
                                                    : ({1'b0, ref_h_q} - {1'b0, h_new});
  assign per_bad   = hs_rise & ref_valid_q & (delta > TOL);
  // The first frame after entering MEASURE has no full predecessor to compare line counts to.
  assign vl_change = vl_valid_q & (v_new != v_lines);
  assign h_win     = ({1'b0, h_cnt} >= H_LO) && ({1'b0, h_cnt} < H_HI);
  assign v_win     = ({1'b0, v_cnt} >= V_LO) && ({1'b0, v_cnt} < V_HI);

  always_comb begin
    state_d     = state_q;
    stable_d    = stable_q;
    ref_h_d     = ref_h_q;
    ref_valid_d = ref_valid_q;
    frame_ok_d  = frame_ok_q;
    vl_valid_d  = vl_valid_q;
    case (state_q)
      ST_SEARCH: begin
        if (vs_rise) begin
          state_d     = ST_MEASURE;
          stable_d    = 3'd0;
          ref_valid_d = 1'b0;
          frame_ok_d  = 1'b1;
          vl_valid_d  = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (hs_rise && !ref_valid_q) begin
          ref_h_d     = h_new;
          ref_valid_d = 1'b1;
        end
        if (per_bad) frame_ok_d = 1'b0;
        if (h_sat || v_sat) begin
          state_d  = ST_SEARCH;
          stable_d = 3'd0;
        end else if (vs_rise) begin
          frame_ok_d = 1'b1;
          vl_valid_d = 1'b1;
          if (frame_ok_q && !per_bad && !vl_change) begin
            stable_d = stable_q + 3'd1;
            if (stable_q + 3'd1 == LOCK_N) state_d = ST_LOCKED;
          end else begin
            stable_d    = 3'd0;
            ref_valid_d = 1'b0;
          end
        end
      end
      ST_LOCKED: begin
        if (per_bad || h_sat || v_sat || (vs_rise && vl_change)) begin
          state_d  = ST_SEARCH;
          stable_d = 3'd0;
        end
      end
      default: begin
        state_d  = ST_SEARCH;
        stable_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_SEARCH;
      stable_q    <= 3'd0;
      ref_h_q     <= '0;
      ref_valid_q <= 1'b0;
      frame_ok_q  <= 1'b0;
      vl_valid_q  <= 1'b0;
      locked_q    <= 1'b0;
      de_q        <= 1'b0;
      hs_out_q    <= 1'b0;
      vs_out_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      stable_q    <= stable_d;
      ref_h_q     <= ref_h_d;
      ref_valid_q <= ref_valid_d;
      frame_ok_q  <= frame_ok_d;
      vl_valid_q  <= vl_valid_d;
      locked_q    <= (state_d == ST_LOCKED);
      de_q        <= locked_q & h_win & v_win;
      hs_out_q    <= vid.hsync;
      vs_out_q    <= vid.vsync;
    end
  end

  assign vid.display_enable = de_q;
  assign vid.hs_out         = hs_out_q;
  assign vid.vs_out         = vs_out_q;
  assign vid.locked         = locked_q;
  assign vid.h_period       = h_period;
  assign vid.v_lines        = v_lines;
endmodule

// File: tb/tb_cga_hdmi_timing_ctrl.sv
// tb/tb_cga_hdmi_timing_ctrl.sv - directed bench on a scaled-down raster (40 clk x 12 lines)
module tb_cga_hdmi_timing_ctrl;
  localparam int H_W = 10, V_W = 9;
  localparam int H_START = 8, H_ACTIVE = 20, V_START = 3, V_ACTIVE = 6;
  localparam int H_TOL = 2, LOCK_FRAMES = 2;
  localparam int LINE = 40, HS_W = 4, LINES = 12, VS_LINES = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  cga_hdmi_timing_ctrl_if #(.H_W(H_W), .V_W(V_W)) vid ();

  cga_hdmi_timing_ctrl #(
    .H_W(H_W), .V_W(V_W), .H_START(H_START), .H_ACTIVE(H_ACTIVE),
    .V_START(V_START), .V_ACTIVE(V_ACTIVE), .H_TOL(H_TOL), .LOCK_FRAMES(LOCK_FRAMES)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .vid     (vid)
  );

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor, sampled on the falling edge, built only from bench-driven sync timing.
  logic hs_prev = 1'b0, vs_prev = 1'b0, lk_prev = 1'b0, de_prev = 1'b0, rst_prev = 1'b1;
  int cyc = 0, hs_cyc = 0, vs_cyc = 0, line_de = 0, line_idx = 0;
  int de_total = 0, bad_lines = 0, de_unlocked = 0;
  int last_lat = 0, rise_lat = 0, fall_lat = 0, n_falls = 0;
  logic [31:0] rst_outs = '0;
  logic pre_rst_de = 1'b0;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    hs_prev  <= vid.hsync;
    vs_prev  <= vid.vsync;
    lk_prev  <= vid.locked;
    de_prev  <= vid.display_enable;
    rst_prev <= reset_n;
    if (vid.hsync && !hs_prev) begin
      hs_cyc <= cyc;
      if (line_idx >= V_START && line_idx < V_START + V_ACTIVE) begin
        if (line_de != H_ACTIVE) bad_lines <= bad_lines + 1;
      end else if (line_de != 0) begin
        bad_lines <= bad_lines + 1;
      end
      line_de  <= 0;
      line_idx <= (vid.vsync && !vs_prev) ? 0 : line_idx + 1;
    end else if (vid.display_enable) begin
      line_de <= line_de + 1;
    end
    if (vid.vsync && !vs_prev) vs_cyc <= cyc;
    if (vid.display_enable) de_total <= de_total + 1;
    if (vid.display_enable && !lk_prev) de_unlocked <= de_unlocked + 1;
    if (vid.display_enable && !de_prev) last_lat <= cyc - hs_cyc;
    if (vid.locked && !lk_prev) rise_lat <= cyc - vs_cyc;
    if (!vid.locked && lk_prev) begin
      fall_lat <= cyc - hs_cyc;
      n_falls  <= n_falls + 1;
    end
    if (!rst_prev) rst_outs <= {9'd0, vid.display_enable, vid.hs_out, vid.vs_out, vid.locked,
                                vid.h_period, vid.v_lines};
    if (!reset_n && rst_prev) pre_rst_de <= vid.display_enable;
  end

  task automatic drive_line(input int per, input bit vs, input int rst_at);
    for (int c = 0; c < per; c++) begin
      vid.hsync = (c < HS_W);
      vid.vsync = vs;
      reset_n   = (c == rst_at) ? 1'b0 : 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input int odd_line, input int odd_per, input int rst_line, input int rst_at);
    for (int l = 0; l < LINES; l++)
      drive_line((l == odd_line) ? odd_per : LINE, (l < VS_LINES), (l == rst_line) ? rst_at : -1);
  endtask

  int de0, bl0, nf0;

  initial begin
    vid.hsync = 1'b0;
    vid.vsync = 1'b0;
    reset_n   = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("rst_de", 32'(vid.display_enable), 0);
    check_eq("rst_hs_out", 32'(vid.hs_out), 0);
    check_eq("rst_vs_out", 32'(vid.vs_out), 0);
    check_eq("rst_locked", 32'(vid.locked), 0);
    check_eq("rst_h_period", 32'(vid.h_period), 0);
    check_eq("rst_v_lines", 32'(vid.v_lines), 0);

    // Lock acquisition: third vsync edge locks.
    drive_frame(-1, LINE, -1, -1);
    drive_frame(-1, LINE, -1, -1);
    check_eq("unlocked_2_frames", 32'(vid.locked), 0);
    drive_frame(-1, LINE, -1, -1);
    check_eq("locked_3rd_vs", 32'(vid.locked), 1);
    check_eq("lock_rise_lat", 32'(rise_lat), 1);
    check_eq("h_period", 32'(vid.h_period), LINE);
    check_eq("v_lines", 32'(vid.v_lines), LINES);

    // Active window on a locked frame.
    de0 = de_total;
    bl0 = bad_lines;
    drive_frame(-1, LINE, -1, -1);
    check_eq("de_per_frame", 32'(de_total - de0), H_ACTIVE * V_ACTIVE);
    check_eq("de_line_shape", 32'(bad_lines - bl0), 0);
    check_eq("de_first_lat", 32'(last_lat), H_START + 2);
    check_eq("still_locked", 32'(vid.locked), 1);

    // One line +3 clk long: lock drops, then relocks.
    nf0 = n_falls;
    drive_frame(5, LINE + 3, -1, -1);
    check_eq("long_line_unlock", 32'(vid.locked), 0);
    check_eq("long_line_fall_lat", 32'(fall_lat), 1);
    check_eq("long_line_falls", 32'(n_falls - nf0), 1);
    drive_frame(-1, LINE, -1, -1);
    drive_frame(-1, LINE, -1, -1);
    check_eq("relock_not_yet", 32'(vid.locked), 0);
    drive_frame(-1, LINE, -1, -1);
    check_eq("relock", 32'(vid.locked), 1);

    // +-2 jitter holds lock; a -3 line loses it.
    nf0 = n_falls;
    for (int l = 0; l < LINES; l++) drive_line(LINE + ((l % 2) != 0 ? -2 : 2), (l < VS_LINES), -1);
    check_eq("jitter2_locked", 32'(vid.locked), 1);
    check_eq("jitter2_no_fall", 32'(n_falls - nf0), 0);
    drive_frame(3, LINE - 3, -1, -1);
    check_eq("jitter3_unlock", 32'(vid.locked), 0);
    check_eq("jitter3_fall_lat", 32'(fall_lat), 1);
    repeat (3) drive_frame(-1, LINE, -1, -1);
    check_eq("relock_after_jitter", 32'(vid.locked), 1);

    // hsync stops: h_cnt saturates at 1023 and lock drops.
    vid.hsync = 1'b0;
    vid.vsync = 1'b0;
    repeat (1100) begin
      @(posedge clk);
      #1;
    end
    check_eq("sat_unlock", 32'(vid.locked), 0);
    check_eq("sat_fall_lat", 32'(fall_lat), 1025);
    repeat (3) drive_frame(-1, LINE, -1, -1);
    check_eq("relock_after_sat", 32'(vid.locked), 1);
    check_eq("v_lines_after_sat", 32'(vid.v_lines), LINES);

    // One-clock reset in the middle of an active line.
    drive_frame(-1, LINE, 4, 15);
    check_eq("pre_reset_de", 32'(pre_rst_de), 1);
    check_eq("reset_outputs", rst_outs, 0);
    drive_frame(-1, LINE, -1, -1);
    drive_frame(-1, LINE, -1, -1);
    check_eq("reset_relock_not_yet", 32'(vid.locked), 0);
    drive_frame(-1, LINE, -1, -1);
    check_eq("reset_relock", 32'(vid.locked), 1);
    check_eq("de_while_unlocked", 32'(de_unlocked), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
